// File: rtl/sap_pkg.sv
// Shared SAP-1 controller definitions: opcodes, one-hot T-states and the
// control-word layout used by the sequencer and the top-level wiring.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam int CW_W = 12;

    localparam int CW_PC_INC       = 11;
    localparam int CW_PC_O_EN      = 10;
    localparam int CW_LOW_MAR_I_EN = 9;
    localparam int CW_LOW_RAM_O_EN = 8;
    localparam int CW_LOW_IR_I_EN  = 7;
    localparam int CW_LOW_IR_O_EN  = 6;
    localparam int CW_LOW_ACC_I_EN = 5;
    localparam int CW_ACC_O_EN     = 4;
    localparam int CW_ALU_SUB      = 3;
    localparam int CW_ALU_O_EN     = 2;
    localparam int CW_LOW_B_I_EN   = 1;
    localparam int CW_LOW_OUT_I_EN = 0;

    // All active-low strobes high, all active-high enables low.
    localparam logic [CW_W-1:0] CW_NOP = 12'b0011_1110_0011;

endpackage

// File: rtl/ring_counter_6.sv
// Six-state one-hot ring (T1..T6) advancing on the falling edge of clk.
// Async reset parks it in T6 so the first edge after reset enters T1.
module ring_counter_6
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [5:0] state,
    output logic [5:0] next_state
);

    t_state_e cur;
    t_state_e nxt;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cur <= T6;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (!hold) begin
            case (cur)
                T1:      nxt = T2;
                T2:      nxt = T3;
                T3:      nxt = T4;
                T4:      nxt = T5;
                T5:      nxt = T6;
                T6:      nxt = T1;
                default: nxt = T1;  // recover from a corrupted ring
            endcase
        end
    end

    assign state      = cur;
    assign next_state = nxt;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: turns the T-state ring and the IR opcode into
// a registered bus control word, updated on the falling edge of clk.
module controller_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4
)
(
    input  logic                clk,
    input  logic                async_reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_o_en,
    output logic                low_mar_i_en,
    output logic                low_ram_o_en,
    output logic                low_ir_i_en,
    output logic                low_ir_o_en,
    output logic                low_acc_i_en,
    output logic                acc_o_en,
    output logic                alu_sub,
    output logic                alu_o_en,
    output logic                low_b_i_en,
    output logic                low_out_i_en,
    output logic                halt,
    output logic [5:0]          t_state
);

    logic [5:0]          next_state;
    logic [OPCODE_W-1:0] op_q;
    logic [CW_W-1:0]     cw_q;
    logic [CW_W-1:0]     cw_d;
    logic                halt_d;

    ring_counter_6 u_ring (
        .clk        (clk),
        .rst        (async_reset),
        .hold       (halt),
        .state      (t_state),
        .next_state (next_state)
    );

    always_ff @(negedge clk or posedge async_reset) begin
        if (async_reset) begin
            cw_q <= CW_NOP;
            halt <= 1'b0;
            op_q <= '0;
        end else begin
            cw_q <= cw_d;
            halt <= halt_d;
            // T5/T6 decode from this copy, so opcode may move after T4.
            if (!halt && next_state == T4) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        cw_d   = CW_NOP;
        halt_d = halt;
        if (!halt) begin
            case (next_state)
                T1: begin
                    cw_d[CW_PC_O_EN]      = 1'b1;
                    cw_d[CW_LOW_MAR_I_EN] = 1'b0;
                end
                T2: cw_d[CW_PC_INC] = 1'b1;
                T3: begin
                    cw_d[CW_LOW_RAM_O_EN] = 1'b0;
                    cw_d[CW_LOW_IR_I_EN]  = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw_d[CW_LOW_IR_O_EN]  = 1'b0;
                            cw_d[CW_LOW_MAR_I_EN] = 1'b0;
                        end
                        OP_OUT: begin
                            cw_d[CW_ACC_O_EN]     = 1'b1;
                            cw_d[CW_LOW_OUT_I_EN] = 1'b0;
                        end
                        OP_HLT:  halt_d = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (op_q)
                        OP_LDA: begin
                            cw_d[CW_LOW_RAM_O_EN] = 1'b0;
                            cw_d[CW_LOW_ACC_I_EN] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw_d[CW_LOW_RAM_O_EN] = 1'b0;
                            cw_d[CW_LOW_B_I_EN]   = 1'b0;
                            cw_d[CW_ALU_SUB]      = (op_q == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        cw_d[CW_ALU_O_EN]     = 1'b1;
                        cw_d[CW_LOW_ACC_I_EN] = 1'b0;
                        cw_d[CW_ALU_SUB]      = (op_q == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_inc       = cw_q[CW_PC_INC];
    assign pc_o_en      = cw_q[CW_PC_O_EN];
    assign low_mar_i_en = cw_q[CW_LOW_MAR_I_EN];
    assign low_ram_o_en = cw_q[CW_LOW_RAM_O_EN];
    assign low_ir_i_en  = cw_q[CW_LOW_IR_I_EN];
    assign low_ir_o_en  = cw_q[CW_LOW_IR_O_EN];
    assign low_acc_i_en = cw_q[CW_LOW_ACC_I_EN];
    assign acc_o_en     = cw_q[CW_ACC_O_EN];
    assign alu_sub      = cw_q[CW_ALU_SUB];
    assign alu_o_en     = cw_q[CW_ALU_O_EN];
    assign low_b_i_en   = cw_q[CW_LOW_B_I_EN];
    assign low_out_i_en = cw_q[CW_LOW_OUT_I_EN];

endmodule
